// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_pkg                                                            |
// | Shared RV32M multiply/divide encodings, states and constants.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package riscv_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;
   localparam logic [XLEN-1:0] SIGNED_MIN        = 32'h8000_0000;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } muldiv_state_e;

   function automatic logic op_is_div(input muldiv_op_e op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic op_is_rem(input muldiv_op_e op);
      return op inside {OP_REM, OP_REMU};
   endfunction

   function automatic logic op_a_signed(input muldiv_op_e op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic op_b_signed(input muldiv_op_e op);
      return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_if                                                            |
// | Request/response bundle between the core and the muldiv unit.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface muldiv_if #(
   parameter int s = 32
);
   logic         start;
   logic [2:0]   funct3;
   logic [s-1:0] rs1_value;
   logic [s-1:0] rs2_value;
   logic [4:0]   rd;
   logic         busy;
   logic         done;
   logic         register_write;
   logic [s-1:0] result;
   logic [4:0]   rd_out;

   modport master (
      output start, funct3, rs1_value, rs2_value, rd,
      input  busy, done, register_write, result, rd_out
   );

   modport slave (
      input  start, funct3, rs1_value, rs2_value, rd,
      output busy, done, register_write, result, rd_out
   );
endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_step                                                          |
// | One shift-add multiply or restoring-divide iteration on {hi,lo}.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module muldiv_step #(
   parameter int s = 32
) (
   input  logic         is_div,
   input  logic [s-1:0] hi,
   input  logic [s-1:0] lo,
   input  logic [s-1:0] opnd,
   output logic [s-1:0] hi_next,
   output logic [s-1:0] lo_next
);

   logic [s:0] sum;
   logic [s:0] shifted;
   logic       ge;

   always_comb begin
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      shifted = {hi, lo[s-1]};
      ge      = shifted >= {1'b0, opnd};
      hi_next = sum[s:1];
      lo_next = {sum[0], lo[s-1:1]};
      if (is_div) begin
         // Both outcomes of the trial subtract are below the divisor, so s bits suffice.
         hi_next = ge ? (shifted[s-1:0] - opnd) : shifted[s-1:0];
         lo_next = {lo[s-2:0], ge};
      end
   end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_unit                                                          |
// | Iterative RV32M multiply/divide unit, 33-cycle latency per op.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module muldiv_unit
   import riscv_pkg::*;
#(
   parameter int s = XLEN
) (
   input  logic      clk,
   input  logic      reset,
   muldiv_if.slave   bus
);

   muldiv_state_e state_q, state_d;
   muldiv_op_e    op_q, op_d, req_op;
   logic [4:0]    count_q, count_d;
   logic          neg_a_q, neg_a_d, neg_b_q, neg_b_d;
   logic [s-1:0]  hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
   logic          busy_q, busy_d, done_q, done_d;
   logic [s-1:0]  result_q, result_d;
   logic [4:0]    rd_out_q, rd_out_d;

   logic          req_neg_a, req_neg_b, div_zero, div_ovf;
   logic [s-1:0]  a_mag, b_mag, special_result;
   logic [s-1:0]  step_hi, step_lo;
   logic [2*s-1:0] product, product_fix;
   logic [s-1:0]  quot_fix, rem_fix, final_result;

   muldiv_step #(.s(s)) u_step (
      .is_div  (op_is_div(op_q)),
      .hi      (hi_q),
      .lo      (lo_q),
      .opnd    (opnd_q),
      .hi_next (step_hi),
      .lo_next (step_lo)
   );

   always_comb begin
      req_op    = muldiv_op_e'(bus.funct3);
      req_neg_a = op_a_signed(req_op) & bus.rs1_value[s-1];
      req_neg_b = op_b_signed(req_op) & bus.rs2_value[s-1];
      a_mag     = req_neg_a ? -bus.rs1_value : bus.rs1_value;
      b_mag     = req_neg_b ? -bus.rs2_value : bus.rs2_value;
      div_zero  = op_is_div(req_op) && (bus.rs2_value == '0);
      div_ovf   = (req_op == OP_DIV || req_op == OP_REM) &&
                  (bus.rs1_value == SIGNED_MIN) && (bus.rs2_value == '1);
      if (div_zero)
         special_result = op_is_rem(req_op) ? bus.rs1_value : DIV_ZERO_QUOTIENT;
      else
         special_result = (req_op == OP_DIV) ? SIGNED_MIN : '0;

      // Sign fix-up uses the final iteration's output so result lands on entry to DONE.
      product     = {step_hi, step_lo};
      product_fix = (neg_a_q ^ neg_b_q) ? -product : product;
      quot_fix    = (neg_a_q ^ neg_b_q) ? -step_lo : step_lo;
      rem_fix     = neg_a_q ? -step_hi : step_hi;
      case (op_q)
         OP_MUL:                     final_result = product_fix[s-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: final_result = product_fix[2*s-1:s];
         OP_DIV, OP_DIVU:            final_result = quot_fix;
         default:                    final_result = rem_fix;
      endcase

      state_d  = state_q;
      op_d     = op_q;
      count_d  = count_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      opnd_d   = opnd_q;
      done_d   = 1'b0;
      result_d = result_q;
      rd_out_d = rd_out_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               op_d     = req_op;
               neg_a_d  = req_neg_a;
               neg_b_d  = req_neg_b;
               rd_out_d = bus.rd;
               count_d  = '0;
               hi_d     = '0;
               lo_d     = op_is_div(req_op) ? a_mag : b_mag;
               opnd_d   = op_is_div(req_op) ? b_mag : a_mag;
               if (div_zero || div_ovf) begin
                  result_d = special_result;
                  done_d   = 1'b1;
                  state_d  = ST_DONE;
               end else begin
                  state_d  = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            hi_d = step_hi;
            lo_d = step_lo;
            if (count_q == 5'd31) begin
               count_d  = '0;
               result_d = final_result;
               done_d   = 1'b1;
               state_d  = ST_DONE;
            end else begin
               count_d = count_q + 5'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_MUL;
         count_q  <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         rd_out_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         count_q  <= count_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opnd_q   <= opnd_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         rd_out_q <= rd_out_d;
      end
   end

   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.register_write = done_q;
   assign bus.result         = result_q;
   assign bus.rd_out         = rd_out_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_muldiv_unit                                                       |
// | Directed plus randomized checks of muldiv_unit against RV32M rules.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_muldiv_unit;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   muldiv_if #(.s(32)) bus ();

   muldiv_unit #(.s(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Architectural RV32M result computed with wide integer arithmetic.
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (f)
         3'b000: begin p = sa * sb;            return p[31:0];  end
         3'b001: begin p = sa * sb;            return p[63:32]; end
         3'b010: begin p = sa * longint'(ub); return p[63:32]; end
         3'b011: begin p = ua * ub;            return p[63:32]; end
         3'b100: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            p = sa / sb; return p[31:0];
         end
         3'b101: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'b110: begin
            if (b == 32'd0) return a;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 32'd0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f < 3'b100) return 1'b0;
      if (b == 32'd0) return 1'b1;
      return (f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
   endfunction

   // Issues one op from an IDLE cycle; optionally disturbs inputs and start while it runs.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rdi, input bit noisy, input string tag);
      logic [31:0] exp;
      int          lat;
      int          cyc;
      exp = model(f, a, b);
      lat = is_special(f, a, b) ? 0 : 32;
      bus.funct3    = f;
      bus.rs1_value = a;
      bus.rs2_value = b;
      bus.rd        = rdi;
      bus.start     = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check({tag, "/busy"}, {31'd0, bus.busy}, 32'd1);
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 40) begin
         if (noisy) begin
            bus.rs1_value = $urandom;
            bus.rs2_value = $urandom;
            bus.funct3    = 3'($urandom);
            bus.rd        = 5'($urandom);
            bus.start     = (cyc < 28) ? 1'($urandom) : 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "/latency"}, 32'(cyc), 32'(lat));
      check({tag, "/result"}, bus.result, exp);
      check({tag, "/rd_out"}, {27'd0, bus.rd_out}, {27'd0, rdi});
      check({tag, "/regwr"}, {31'd0, bus.register_write}, 32'd1);
      @(posedge clk); #1;
      check({tag, "/done_low"}, {30'd0, bus.done, bus.register_write}, 32'd0);
      check({tag, "/idle"}, {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      logic [2:0]  f;
      logic [31:0] a, b;
      bit          saw_write;

      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.funct3    = 3'd0;
      bus.rs1_value = 32'd0;
      bus.rs2_value = 32'd0;
      bus.rd        = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset/busy", {31'd0, bus.busy}, 32'd0);
      check("reset/done", {31'd0, bus.done}, 32'd0);
      check("reset/regwr", {31'd0, bus.register_write}, 32'd0);
      check("reset/result", bus.result, 32'd0);
      check("reset/rd_out", {27'd0, bus.rd_out}, 32'd0);
      reset = 1'b0;

      run_op(3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  1'b0, "mul_7_m3");
      run_op(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  1'b0, "mulhu_m1");
      run_op(3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  1'b0, "mulh_m1");
      run_op(3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  1'b0, "mulhsu_m1");
      run_op(3'b100, 32'hFFFF_FFF9,  32'd2,         5'd9,  1'b0, "div_m7_2");
      run_op(3'b110, 32'hFFFF_FFF9,  32'd2,         5'd10, 1'b0, "rem_m7_2");
      run_op(3'b101, 32'd100,        32'd7,         5'd11, 1'b0, "divu_100_7");
      run_op(3'b101, 32'h0000_1234,  32'd0,         5'd12, 1'b0, "divu_by0");
      run_op(3'b111, 32'h0000_1234,  32'd0,         5'd13, 1'b0, "remu_by0");
      run_op(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 1'b0, "div_ovf");
      run_op(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 1'b0, "rem_ovf");
      run_op(3'b001, 32'h8000_0000,  32'h8000_0000, 5'd16, 1'b1, "mulh_min_noisy");
      run_op(3'b100, 32'd1000,       32'hFFFF_FFFD, 5'd17, 1'b1, "div_noisy");

      // Abort mid-operation: no write pulse may follow.
      bus.funct3    = 3'b000;
      bus.rs1_value = 32'd1234;
      bus.rs2_value = 32'd5678;
      bus.rd        = 5'd20;
      bus.start     = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      saw_write = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus.register_write === 1'b1) saw_write = 1'b1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort/busy", {31'd0, bus.busy}, 32'd0);
      check("abort/done", {31'd0, bus.done}, 32'd0);
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.register_write !== 1'b0) saw_write = 1'b1;
      end
      check("abort/no_write", {31'd0, saw_write}, 32'd0);
      run_op(3'b000, 32'd3, 32'd4, 5'd21, 1'b0, "mul_after_abort");

      for (int i = 0; i < 24; i++) begin
         f = 3'($urandom);
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            default: ;
         endcase
         run_op(f, a, b, 5'($urandom), 1'(i % 2), $sformatf("rand%0d_f%0d", i, f));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit. It consumes the two source operands read from the register file together with the destination index, computes one M-extension operation over multiple cycles, and returns the result with a one-cycle write-enable for the register file write port. The control path stalls the core while `busy` is high.

## Interface

Parameters:
- `s`, default 32: operand/result width; all arithmetic rules below are for `s`=32.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: request to begin an operation; sampled only in IDLE.
- `funct3`, input, 3: M-extension op select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_value`, input, s: operand A (dividend or multiplicand).
- `rs2_value`, input, s: operand B (divisor or multiplier).
- `rd`, input, 5: destination register index, captured with the operands.
- `busy`, output, 1: high whenever state is not IDLE.
- `done`, output, 1: single-cycle pulse; `result` and `rd_out` are valid in that cycle.
- `register_write`, output, 1: equal to `done`; drives the register-file write enable.
- `result`, output, s: computed value. Holds its last value until the next `done`.
- `rd_out`, output, 5: captured `rd`. Holds until the next accept.

## Operation

- **FSM states.**
  - IDLE: on `start` with a normal op, go to RUN. On `start` with a special case, go to DONE.
  - RUN: 32 iterations, counter 0..31. Go to DONE when the counter reaches 31.
  - DONE: 1 cycle, then IDLE.
- **Accept.** `start` is honoured only in IDLE. Accepting latches `funct3`, `rd`, the operand magnitudes and the sign flags. `start` in RUN or DONE is ignored and is not queued.
- **Operand signs.** MUL, MULH, DIV and REM treat both operands as signed. MULHSU treats A as signed and B as unsigned. MULHU, DIVU and REMU treat both as unsigned. The unit iterates on magnitudes.
- **Multiply.** Shift-add, one multiplier bit per iteration, into a 64-bit product. The final sign is the XOR of the operand signs, applied as a 64-bit two's-complement negate on entry to DONE.
  - MUL returns product[31:0].
  - MULH, MULHSU and MULHU return product[63:32].
- **Divide.** Restoring division, one quotient bit per iteration.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - DIV and DIVU return the quotient; REM and REMU return the remainder.
- **Special cases**, resolved at accept, bypass RUN, `done` one cycle after accept:
  - Divide by zero: DIV and DIVU return 0xFFFFFFFF; REM and REMU return A.
  - Signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- **Operand capture.** `rs1_value` and `rs2_value` may change after the accept edge without affecting the result.

## Timing

- **Reset.** Synchronous. Sets state to IDLE, counter 0, and clears `busy`, `done`, `register_write`, `result` and `rd_out` to 0. Asserting `reset` in RUN or DONE aborts the operation with no write pulse. `reset` overrides a simultaneous `start`.
- **Accept edge = E0.**
  - `busy` is high from E0 until the edge that leaves DONE.
  - Normal ops: iterations occur at E1..E32, state is DONE after E32, and `done`/`register_write` are high for exactly one cycle, E32→E33 (33-cycle latency). Back in IDLE after E33.
  - Special cases: `done` is high for the cycle E0→E1.
- **Back-to-back.** `start` held high in the IDLE cycle following DONE is accepted at that edge. The minimum issue interval is 34 cycles for normal ops.
- **Outputs.** All outputs are registered; there is no combinational path from inputs to outputs.

## Structure

- **Shared package `riscv_pkg`:**
  - `muldiv_op_e` enum of `funct3` encodings.
  - `muldiv_state_e` enum (IDLE, RUN, DONE).
  - Constants XLEN=32 and the 0xFFFFFFFF / 0x80000000 special-case values.
- **Sub-module.** One sub-module is natural: `muldiv_step`, a combinational single-iteration datapath (add-or-skip for multiply, trial-subtract for divide) instantiated once by `muldiv_unit`. The FSM, counter, sign fix-up and special-case detection remain in `muldiv_unit`.

## Test plan

- MUL with A=7, B=0xFFFFFFFD (-3), rd=5 → after 33 cycles `done`=1 and `register_write`=1 for one cycle, `result`=0xFFFFFFEB, `rd_out`=5.
- MULHU with A=B=0xFFFFFFFF → `result`=0xFFFFFFFE. MULH with the same operands → `result`=0x00000000.
- DIV with A=0xFFFFFFF9 (-7), B=2 → `result`=0xFFFFFFFD. REM with the same operands → `result`=0xFFFFFFFF. DIVU with A=100, B=7 → `result`=14.
- DIVU with A=0x1234, B=0 → `done` one cycle after accept, `result`=0xFFFFFFFF. REMU with the same operands → `result`=0x1234. DIV with A=0x80000000, B=0xFFFFFFFF → `result`=0x80000000.
- `start` pulsed repeatedly during RUN, with operands changing after accept → no extra `done`, and the result matches the operands captured at accept.
- `reset` asserted at iteration 10 → `busy`=0 and `done`=0 on the next cycle, and no `register_write` pulse ever appears. A new MUL with A=3, B=4 then returns 12.
